// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter
//   Merges the IF-stage (inst_*) and MEM-stage (data_*) SRAM-like ports onto a
//   single SRAM-like master port (m_*) toward the AXI bridge. Only one
//   transaction is outstanding at a time. The data side has fixed priority,
//   but after STARVE_MAX consecutive data grants with a fetch pending, the
//   fetch is forced to win.
//
// Ports
//   cpu_clk_50M, cpu_rst          clock, synchronous active-high reset
//   inst_req/wr/size/addr/wdata   fetch request in
//   inst_rdata/addr_ok/data_ok    fetch responses out (owner only)
//   data_req/wr/size/addr/wdata   MEM request in
//   data_rdata/addr_ok/data_ok    MEM responses out (owner only)
//   m_req/wr/size/addr/wdata      registered master request out
//   m_addr_ok/data_ok/rdata       master responses in
//   busy                          high whenever not IDLE
module sram_bus_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy
);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] REQ  = 2'b01;
    localparam logic [1:0] WAIT = 2'b10;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic [1:0]       state;
    logic             owner;      // 0 = inst, 1 = data
    logic [CNT_W-1:0] starve_cnt;

    logic data_wins;
    logic addr_fire;
    logic data_fire;

    // Data keeps priority until the fetch has been passed over STARVE_MAX times.
    assign data_wins = data_req && (!inst_req || (starve_cnt < STARVE_LIM));
    assign addr_fire = (state == REQ)  && m_addr_ok;
    assign data_fire = (state == WAIT) && m_data_ok;

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            starve_cnt <= '0;
            m_req      <= 1'b0;
            m_wr       <= 1'b0;
            m_size     <= '0;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        m_req <= 1'b1;
                        state <= REQ;
                        if (data_wins) begin
                            owner   <= 1'b1;
                            m_wr    <= data_wr;
                            m_size  <= data_size;
                            m_addr  <= data_addr;
                            m_wdata <= data_wdata;
                            // Count only grants that bypass a waiting fetch.
                            if (inst_req) begin
                                if (starve_cnt != STARVE_LIM) begin
                                    starve_cnt <= starve_cnt + CNT_W'(1);
                                end
                            end else begin
                                starve_cnt <= '0;
                            end
                        end else begin
                            owner      <= 1'b0;
                            m_wr       <= inst_wr;
                            m_size     <= inst_size;
                            m_addr     <= inst_addr;
                            m_wdata    <= inst_wdata;
                            starve_cnt <= '0;
                        end
                    end
                end
                REQ: begin
                    if (m_addr_ok) begin
                        m_req <= 1'b0;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        inst_addr_ok = addr_fire && !owner;
        data_addr_ok = addr_fire &&  owner;
        inst_data_ok = data_fire && !owner;
        data_data_ok = data_fire &&  owner;
        inst_rdata   = inst_data_ok ? m_rdata : '0;
        data_rdata   = data_data_ok ? m_rdata : '0;
        busy         = (state != IDLE);
    end

endmodule
